// File: rtl/soc_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the arbiter state encoding, memory command constants and the DMA address helper.
package soc_pkg;

  typedef enum logic {ARB_CPU = 1'b0, ARB_DMA = 1'b1} arb_state_e;

  localparam logic       MEM_READ   = 1'b0;
  localparam logic       MEM_WRITE  = 1'b1;
  localparam logic [3:0] WSTRB_FULL = 4'hF;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// ADC sample FIFO; head is visible combinationally, writes land at the next edge.
// Push while full is dropped unless a pop happens in the same cycle; flush empties it in one cycle.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_adc_arbiter.sv
// Shares the data-memory port between the CPU and an ADC capture DMA writing a circular buffer.
// Memory outputs are combinational from the grant; the CPU is stalled (cpu_gnt=0) while the DMA drains.
module dmem_adc_arbiter
  import soc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HIWATER    = 3,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [3:0]  cpu_wstrobe,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic [31:0] adc_in,
  input  logic        cfg_en,
  input  logic [15:0] cfg_div,
  input  logic [31:0] cfg_base,
  input  logic [15:0] cfg_words,
  output logic        dma_wrap,
  output logic        dma_overflow,
  output logic        mem_rw,
  output logic [3:0]  mem_wstrobe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [15:0]   r_timer;
  logic [15:0]   r_idx;
  logic [WW-1:0] r_wait;
  logic [WW-1:0] w_wait_nxt;
  logic          r_ovf;
  logic          r_rd_pend;

  logic          w_active;
  logic          w_push;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;
  logic          w_last_idx;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_head;

  assign w_active   = cfg_en && (cfg_words != 16'd0);
  assign w_push     = w_active && (r_timer == cfg_div);
  assign w_last_idx = (r_idx == cfg_words - 16'd1);
  assign w_drop     = w_push && w_full && !w_dma_gnt;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_dma_gnt),
    .flush (!w_active),
    .din   (adc_in),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // Starvation counter saturates so it cannot wrap while the CPU keeps winning.
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_dma_gnt)                                w_wait_nxt = '0;
    else if (!w_empty && r_wait != WW'(MAX_WAIT)) w_wait_nxt = r_wait + 1'b1;
  end

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_state_nxt = r_state;
    if (!reset) begin
      case (r_state)
        ARB_DMA: w_dma_gnt = !w_empty;
        default: begin
          w_cpu_gnt = cpu_req;
          w_dma_gnt = !cpu_req && !w_empty;
        end
      endcase
    end
    case (r_state)
      ARB_CPU: if (w_count >= CW'(HIWATER) || w_wait_nxt >= WW'(MAX_WAIT)) w_state_nxt = ARB_DMA;
      // Leave once this cycle's pop empties the FIFO and no sample arrives to refill it.
      ARB_DMA: if (!w_push && w_count <= CW'(1)) w_state_nxt = ARB_CPU;
      default: w_state_nxt = ARB_CPU;
    endcase
    if (!w_active) w_state_nxt = ARB_CPU;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARB_CPU;
      r_timer   <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_ovf     <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_cpu_gnt && (cpu_rw == MEM_READ);
      if (!w_active) begin
        r_timer <= '0;
        r_idx   <= '0;
        r_wait  <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_timer <= w_push ? 16'd0 : r_timer + 16'd1;
        r_wait  <= w_wait_nxt;
        if (w_dma_gnt) r_idx <= w_last_idx ? 16'd0 : r_idx + 16'd1;
        if (w_drop)    r_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_rw      = 1'b0;
    mem_wstrobe = 4'h0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    if (w_dma_gnt) begin
      mem_rw      = MEM_WRITE;
      mem_wstrobe = WSTRB_FULL;
      mem_addr    = word_addr(cfg_base, r_idx);
      mem_wdata   = w_head;
    end else if (w_cpu_gnt) begin
      mem_rw      = cpu_rw;
      mem_wstrobe = cpu_wstrobe;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
    end
  end

  assign cpu_gnt      = w_cpu_gnt;
  assign cpu_rvalid   = r_rd_pend && !reset;
  assign cpu_rdata    = cpu_rvalid ? mem_rdata : 32'h0;
  assign dma_wrap     = w_dma_gnt && w_last_idx;
  assign dma_overflow = r_ovf && !reset;

endmodule

// File: tb/tb_dmem_adc_arbiter.sv
// Randomised and directed bench for dmem_adc_arbiter against a queue-based reference model.
module tb_dmem_adc_arbiter;
  import soc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw;
  logic [3:0]  cpu_wstrobe;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic [31:0] adc_in;
  logic        cfg_en;
  logic [15:0] cfg_div, cfg_words;
  logic [31:0] cfg_base;
  logic        dma_wrap, dma_overflow;
  logic        mem_rw;
  logic [3:0]  mem_wstrobe;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_adc_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_wstrobe(cpu_wstrobe),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .adc_in(adc_in), .cfg_en(cfg_en), .cfg_div(cfg_div),
    .cfg_base(cfg_base), .cfg_words(cfg_words),
    .dma_wrap(dma_wrap), .dma_overflow(dma_overflow),
    .mem_rw(mem_rw), .mem_wstrobe(mem_wstrobe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: sample queue, buffer index, priority mode flag and plain counters.
  logic [31:0] q[$];
  bit m_dma, m_ovf, m_pend, m_force_cpu;
  int m_wait, m_timer, m_idx;

  logic        obs_gnt, obs_rw, obs_wrap, obs_ovf, obs_rvalid;
  logic [31:0] obs_addr, obs_rdata;

  task automatic model_clear();
    q.delete();
    m_dma = 0; m_ovf = 0; m_wait = 0; m_timer = 0; m_idx = 0;
  endtask

  task automatic cycle();
    bit act, g_cpu, g_dma, e_wrap;
    logic e_rw;
    logic [3:0] e_strb;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int occ;
    @(negedge clk);
    act = cfg_en && (cfg_words != 0);
    g_cpu = 0; g_dma = 0;
    if (!reset) begin
      if (m_dma && !m_force_cpu) g_dma = (q.size() > 0);
      else begin
        g_cpu = cpu_req;
        g_dma = !cpu_req && (q.size() > 0);
      end
    end
    e_rw = 0; e_strb = 0; e_addr = 0; e_wdata = 0;
    if (g_dma) begin
      e_rw = 1; e_strb = 4'hF; e_addr = cfg_base + 32'(m_idx) * 4; e_wdata = q[0];
    end else if (g_cpu) begin
      e_rw = cpu_rw; e_strb = cpu_wstrobe; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end
    e_wrap  = g_dma && (m_idx == int'(cfg_words) - 1);
    e_rdata = (m_pend && !reset) ? mem_rdata : 32'h0;
    chk("cpu_gnt", cpu_gnt, g_cpu);
    chk("cpu_rvalid", cpu_rvalid, m_pend && !reset);
    chk("cpu_rdata", cpu_rdata, e_rdata);
    chk("mem_rw", mem_rw, e_rw);
    chk("mem_wstrobe", mem_wstrobe, e_strb);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("dma_wrap", dma_wrap, e_wrap);
    chk("dma_overflow", dma_overflow, m_ovf && !reset);
    obs_gnt = cpu_gnt; obs_rw = mem_rw; obs_wrap = dma_wrap; obs_ovf = dma_overflow;
    obs_rvalid = cpu_rvalid; obs_addr = mem_addr; obs_rdata = cpu_rdata;
    if (reset) begin
      model_clear();
      m_pend = 0;
    end else begin
      m_pend = g_cpu && !cpu_rw;
      if (!act) model_clear();
      else begin
        occ = q.size();
        if (g_dma) begin
          void'(q.pop_front());
          m_idx = (m_idx + 1) % int'(cfg_words);
        end
        if (m_timer == int'(cfg_div)) begin
          m_timer = 0;
          if (occ == 4 && !g_dma) m_ovf = 1;
          else q.push_back(adc_in);
        end else m_timer++;
        if (g_dma) m_wait = 0;
        else if (occ > 0) m_wait++;
        if (!m_dma) begin
          if (occ >= 3 || m_wait >= 8) m_dma = 1;
        end else if (q.size() == 0) m_dma = 0;
        if (m_force_cpu) m_dma = 0;
      end
    end
    @(posedge clk);
    #1;
    adc_in    = $urandom;
    mem_rdata = $urandom;
  endtask

  // New CPU request only once the previous one was granted (request held stable otherwise).
  task automatic next_cpu(input int pct);
    if (!cpu_req || obs_gnt) begin
      cpu_req     = ($urandom_range(0, 99) < pct);
      cpu_rw      = $urandom_range(0, 1);
      cpu_wstrobe = 4'($urandom);
      cpu_addr    = $urandom;
      cpu_wdata   = $urandom;
    end
  endtask

  logic [31:0] fill_exp [4];
  logic [31:0] fill_addr [4];
  logic        fill_wrap [4];
  int nw, first_dma, burst, restart_addr;
  bit gnt15, seen;

  initial begin
    fill_exp[0] = 32'h2000; fill_exp[1] = 32'h2004; fill_exp[2] = 32'h2008; fill_exp[3] = 32'h2000;
    reset = 1; cpu_req = 1; cpu_rw = 0; cpu_wstrobe = 4'hF; cpu_addr = 32'h40; cpu_wdata = 0;
    cfg_en = 0; cfg_div = 0; cfg_base = 0; cfg_words = 0;
    adc_in = $urandom; mem_rdata = $urandom;
    m_force_cpu = 0; m_pend = 0; obs_gnt = 0;
    model_clear();
    repeat (3) cycle();
    reset = 0; cpu_req = 0;
    cycle();

    // CPU-only read and write
    cpu_req = 1; cpu_rw = 0; cpu_addr = 32'h100; cpu_wstrobe = 4'h0;
    cycle();
    chk("cpu_read_gnt", obs_gnt, 1);
    cpu_req = 0; mem_rdata = 32'hDEADBEEF;
    cycle();
    chk("cpu_read_rvalid", obs_rvalid, 1);
    chk("cpu_read_data", obs_rdata, 32'hDEADBEEF);
    cpu_req = 1; cpu_rw = 1; cpu_addr = 32'h200; cpu_wdata = 32'h12345678; cpu_wstrobe = 4'h3;
    cycle();
    cpu_req = 0;
    cycle();

    // Idle fill of a 3-word buffer
    cfg_en = 1; cfg_div = 0; cfg_base = 32'h2000; cfg_words = 3;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_rw && nw < 4) begin
        fill_addr[nw] = obs_addr; fill_wrap[nw] = obs_wrap; nw++;
      end
    end
    chk("fill_count", nw, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill_addr%0d", k), fill_addr[k], fill_exp[k]);
      chk($sformatf("fill_wrap%0d", k), fill_wrap[k], k == 2);
    end
    cfg_en = 0;
    cycle();

    // Starvation: CPU always requesting, slow sampling
    cfg_div = 3; cfg_base = 32'h3000; cfg_words = 16; cfg_en = 1; cpu_req = 1;
    first_dma = -1; burst = 0; gnt15 = 0;
    for (int i = 0; i < 30; i++) begin
      cpu_rw = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
      cycle();
      if (!obs_gnt && obs_rw) begin
        if (first_dma < 0) first_dma = i;
        if (i < 20) burst++;
      end
      if (i == 15) gnt15 = obs_gnt;
    end
    chk("starve_first_dma", first_dma, 12);
    chk("starve_burst", burst, 3);
    chk("starve_back_cpu", gnt15, 1);
    cfg_en = 0;
    cycle();

    // High-water: every-cycle sampling against continuous CPU traffic
    cfg_div = 0; cfg_base = 32'h5000; cfg_words = 5; cfg_en = 1; cpu_req = 1;
    first_dma = -1; burst = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!obs_gnt && obs_rw) begin
        if (first_dma < 0) first_dma = i;
        burst++;
      end
    end
    chk("hiwater_first_dma", first_dma, 4);
    chk("hiwater_dma_cycles", burst, 16);
    chk("hiwater_no_ovf", obs_ovf, 0);
    cfg_en = 0;
    cycle();

    // Overflow: arbiter pinned to the CPU so the FIFO fills without draining
    force dut.r_state = ARB_CPU;
    m_force_cpu = 1;
    cfg_div = 0; cfg_en = 1; cpu_req = 1;
    repeat (10) cycle();
    chk("ovf_set", obs_ovf, 1);
    cpu_req = 0;
    repeat (3) cycle();
    chk("ovf_sticky", obs_ovf, 1);
    cfg_en = 0;
    cycle();
    cycle();
    chk("ovf_cleared", obs_ovf, 0);
    release dut.r_state;
    m_force_cpu = 0;

    // Mid-operation disable with two samples queued, then restart
    cfg_div = 1; cfg_base = 32'h4000; cfg_words = 8; cfg_en = 1; cpu_req = 1; cpu_rw = 0;
    repeat (4) cycle();
    cfg_en = 0;
    cycle();
    cfg_en = 1; cfg_div = 0; cpu_req = 0;
    cycle();
    chk("flush_no_write", obs_rw, 0);
    seen = 0; restart_addr = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (obs_rw && !seen) begin seen = 1; restart_addr = obs_addr; end
    end
    chk("restart_addr", restart_addr, 32'h4000);
    cfg_en = 0;
    cycle();

    // Randomised segments with fixed config per segment and occasional resets
    for (int s = 0; s < 12; s++) begin
      int pct;
      cfg_en = 0; cpu_req = 0;
      cfg_base = $urandom & 32'hFFFF_FFFC;
      cfg_words = 16'($urandom_range(0, 6));
      cfg_div = 16'($urandom_range(0, 4));
      pct = $urandom_range(10, 95);
      cycle();
      cfg_en = 1;
      for (int i = 0; i < 40; i++) begin
        next_cpu(pct);
        reset = ($urandom_range(0, 59) == 0);
        cycle();
      end
      reset = 0;
    end

    // Reset asserted with a read in flight
    cfg_en = 1; cfg_div = 0; cfg_base = 32'h6000; cfg_words = 4;
    cpu_req = 1; cpu_rw = 0; cpu_addr = 32'h300;
    cycle();
    cpu_req = 0; reset = 1;
    cycle();
    chk("reset_drop_rvalid", obs_rvalid, 0);
    cycle();
    reset = 0; cfg_en = 0;
    cycle();
    chk("post_reset_ovf", obs_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
